// File: rtl/arm_run_ctrl.sv
// arm_run_ctrl: run controller for the ARM core and its memories.
// Holds the core in restart and waits a settle delay. It then preloads
// registers through the debug write port, enables the core and stops
// it on a sentinel watch value or a run-cycle timeout.
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   start           re-launch pulse, used only in HALTED or TIMEOUT
//   watch_data      core register compared with HALT_VALUE
//   cpu_restart     core restart
//   cpu_en          core enable
//   pre_wen         debug register write strobe
//   pre_idx         debug register index
//   pre_wdata       debug register data
//   busy            low only in HALTED and TIMEOUT
//   halted          sticky flag, set when the sentinel is seen
//   timed_out       sticky flag, set when the run limit is reached
//   run_cycles      saturating count of cycles spent in RUN
module arm_run_ctrl #(
    parameter int WIDTH          = 32,
    parameter int IDX_W          = 4,
    parameter int RST_CYCLES     = 5,
    parameter int SETTLE_CYCLES  = 5,
    parameter int NUM_PRELOAD    = 3,
    parameter logic [((NUM_PRELOAD > 0) ? NUM_PRELOAD : 1)*IDX_W-1:0]
        PRELOAD_IDX = {4'd4, 4'd3, 4'd1},
    parameter logic [((NUM_PRELOAD > 0) ? NUM_PRELOAD : 1)*WIDTH-1:0]
        PRELOAD_VAL = {32'h0000ff00, 32'h00000100, 32'h00000200},
    parameter logic [WIDTH-1:0] HALT_VALUE = 32'h0000ff00,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] watch_data,
    output logic             cpu_restart,
    output logic             cpu_en,
    output logic             pre_wen,
    output logic [IDX_W-1:0] pre_idx,
    output logic [WIDTH-1:0] pre_wdata,
    output logic             busy,
    output logic             halted,
    output logic             timed_out,
    output logic [CNT_W-1:0] run_cycles
);

    localparam int CMAX0 = (RST_CYCLES > SETTLE_CYCLES) ?
                           RST_CYCLES : SETTLE_CYCLES;
    localparam int CMAX  = (CMAX0 > NUM_PRELOAD) ? CMAX0 : NUM_PRELOAD;
    localparam int CW    = (CMAX < 2) ? 1 : $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_HOLD,
        S_SETTLE,
        S_PRELOAD,
        S_RUN,
        S_HALTED,
        S_TIMEOUT
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_n;

    logic             restart_d;
    logic             en_d;
    logic             wen_d;
    logic [IDX_W-1:0] idx_d;
    logic [WIDTH-1:0] wdata_d;
    logic             busy_d;
    logic             halted_d;
    logic             timed_out_d;
    logic [CNT_W-1:0] run_cycles_d;

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_HOLD;
            cnt         <= '0;
            cpu_restart <= 1'b1;
            cpu_en      <= 1'b0;
            pre_wen     <= 1'b0;
            pre_idx     <= '0;
            pre_wdata   <= '0;
            busy        <= 1'b1;
            halted      <= 1'b0;
            timed_out   <= 1'b0;
            run_cycles  <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            cpu_restart <= restart_d;
            cpu_en      <= en_d;
            pre_wen     <= wen_d;
            pre_idx     <= idx_d;
            pre_wdata   <= wdata_d;
            busy        <= busy_d;
            halted      <= halted_d;
            timed_out   <= timed_out_d;
            run_cycles  <= run_cycles_d;
        end
    end

    // Next-state logic. In HOLD the counter counts edges since the
    // sequence began, so leaving at cnt==RST_CYCLES gives RST_CYCLES
    // restart cycles after the first edge out of reset.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            S_HOLD: begin
                if (cnt == CW'(RST_CYCLES)) begin
                    cnt_n = '0;
                    if (SETTLE_CYCLES > 0) begin
                        state_n = S_SETTLE;
                    end else if (NUM_PRELOAD > 0) begin
                        state_n = S_PRELOAD;
                    end else begin
                        state_n = S_RUN;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_SETTLE: begin
                if (cnt == CW'(SETTLE_CYCLES - 1)) begin
                    cnt_n = '0;
                    if (NUM_PRELOAD > 0) begin
                        state_n = S_PRELOAD;
                    end else begin
                        state_n = S_RUN;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_PRELOAD: begin
                if (cnt == CW'(NUM_PRELOAD - 1)) begin
                    cnt_n   = '0;
                    state_n = S_RUN;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_RUN: begin
                if (watch_data == HALT_VALUE) begin
                    state_n = S_HALTED;
                end else if (TIMEOUT_CYCLES != 0 &&
                             run_cycles == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_n = S_TIMEOUT;
                end
            end
            S_HALTED, S_TIMEOUT: begin
                // The start edge itself counts as the first HOLD edge,
                // so the replay has the same timing as a reset release.
                if (start) begin
                    state_n = S_HOLD;
                    cnt_n   = CW'(1);
                end
            end
            default: begin
                state_n = S_HOLD;
                cnt_n   = '0;
            end
        endcase
    end

    // Output logic: values the outputs take after the coming edge.
    always_comb begin
        restart_d    = (state_n == S_HOLD);
        en_d         = (state_n == S_RUN);
        wen_d        = (state_n == S_PRELOAD);
        busy_d       = !(state_n == S_HALTED || state_n == S_TIMEOUT);
        idx_d        = '0;
        wdata_d      = '0;
        halted_d     = halted;
        timed_out_d  = timed_out;
        run_cycles_d = run_cycles;

        if (state_n == S_PRELOAD) begin
            for (int i = 0; i < NUM_PRELOAD; i++) begin
                if (cnt_n == CW'(i)) begin
                    idx_d   = PRELOAD_IDX[i*IDX_W +: IDX_W];
                    wdata_d = PRELOAD_VAL[i*WIDTH +: WIDTH];
                end
            end
        end

        if (state == S_RUN) begin
            if (run_cycles != '1) begin
                run_cycles_d = run_cycles + CNT_W'(1);
            end
            if (state_n == S_HALTED) begin
                halted_d = 1'b1;
            end
            if (state_n == S_TIMEOUT) begin
                timed_out_d = 1'b1;
            end
        end

        if ((state == S_HALTED || state == S_TIMEOUT) &&
            state_n == S_HOLD) begin
            halted_d     = 1'b0;
            timed_out_d  = 1'b0;
            run_cycles_d = '0;
        end
    end

endmodule

// File: tb/tb_arm_run_ctrl.sv
// tb_arm_run_ctrl: scoreboard bench for arm_run_ctrl.
// Three instances: defaults, a short timeout, and no preload entries.
module tb_arm_run_ctrl;

    localparam int K_RLEN = 0;
    localparam int K_WR   = 1;
    localparam int K_EN   = 2;
    localparam int K_STOP = 3;
    localparam int K_SNAP = 4;

    typedef struct {
        int          dut;
        int          kind;
        logic [79:0] val;
        string       name;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst        [3];
    logic        start      [3];
    logic [31:0] watch      [3];
    logic        cpu_restart[3];
    logic        cpu_en     [3];
    logic        pre_wen    [3];
    logic [3:0]  pre_idx    [3];
    logic [31:0] pre_wdata  [3];
    logic        busy       [3];
    logic        halted     [3];
    logic        timed_out  [3];
    logic [31:0] run_cycles [3];

    ev_t  exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   tok     [3] = '{0, 0, 0};
    int   last_tok[3] = '{0, 0, 0};
    int   rlen    [3] = '{0, 0, 0};
    int   since   [3] = '{0, 0, 0};
    logic rst_q   [3];
    logic prev_rs [3];
    logic prev_en [3];
    logic prev_bz [3];

    arm_run_ctrl u_def (
        .clk(clk), .rst(rst[0]), .start(start[0]),
        .watch_data(watch[0]),
        .cpu_restart(cpu_restart[0]), .cpu_en(cpu_en[0]),
        .pre_wen(pre_wen[0]), .pre_idx(pre_idx[0]),
        .pre_wdata(pre_wdata[0]), .busy(busy[0]),
        .halted(halted[0]), .timed_out(timed_out[0]),
        .run_cycles(run_cycles[0])
    );

    arm_run_ctrl #(.TIMEOUT_CYCLES(20)) u_to (
        .clk(clk), .rst(rst[1]), .start(start[1]),
        .watch_data(watch[1]),
        .cpu_restart(cpu_restart[1]), .cpu_en(cpu_en[1]),
        .pre_wen(pre_wen[1]), .pre_idx(pre_idx[1]),
        .pre_wdata(pre_wdata[1]), .busy(busy[1]),
        .halted(halted[1]), .timed_out(timed_out[1]),
        .run_cycles(run_cycles[1])
    );

    arm_run_ctrl #(
        .NUM_PRELOAD(0),
        .PRELOAD_IDX(4'h0),
        .PRELOAD_VAL(32'h0)
    ) u_np (
        .clk(clk), .rst(rst[2]), .start(start[2]),
        .watch_data(watch[2]),
        .cpu_restart(cpu_restart[2]), .cpu_en(cpu_en[2]),
        .pre_wen(pre_wen[2]), .pre_idx(pre_idx[2]),
        .pre_wdata(pre_wdata[2]), .busy(busy[2]),
        .halted(halted[2]), .timed_out(timed_out[2]),
        .run_cycles(run_cycles[2])
    );

    function automatic logic [79:0] snapv(
        input logic rs, input logic en, input logic wen,
        input logic [3:0] idx, input logic [31:0] wd,
        input logic bz, input logic h, input logic t,
        input logic [31:0] rc);
        return {6'b0, rs, en, wen, idx, wd, bz, h, t, rc};
    endfunction

    function automatic logic [79:0] wrv(input logic [3:0] idx,
                                        input logic [31:0] wd);
        return {44'b0, idx, wd};
    endfunction

    function automatic logic [79:0] stopv(
        input logic h, input logic t, input logic en,
        input logic rs, input logic [31:0] rc);
        return {44'b0, h, t, en, rs, rc};
    endfunction

    task automatic push(input int d, input int k,
                        input logic [79:0] v, input string n);
        ev_t e;
        e.dut  = d;
        e.kind = k;
        e.val  = v;
        e.name = n;
        exp_q.push_back(e);
    endtask

    task automatic check(input int d, input int k, input logic [79:0] v);
        int f = -1;
        total++;
        foreach (exp_q[i]) begin
            if (f < 0 && exp_q[i].dut == d) f = i;
        end
        if (f < 0) begin
            bad++;
            $display("FAIL dut%0d unexpected: kind=%0d got=%h required=none",
                     d, k, v);
        end else begin
            if (exp_q[f].kind != k || exp_q[f].val !== v) begin
                bad++;
                $display("FAIL dut%0d %s: got kind=%0d val=%h required kind=%0d val=%h",
                         d, exp_q[f].name, k, v, exp_q[f].kind, exp_q[f].val);
            end
            exp_q.delete(f);
        end
    endtask

    task automatic observe(input int d);
        if (cpu_restart[d] === 1'b1 && rst_q[d] === 1'b0) rlen[d]++;
        if (prev_rs[d] === 1'b1 && cpu_restart[d] === 1'b0) begin
            check(d, K_RLEN, 80'(rlen[d]));
            rlen[d] = 0;
        end
        if (pre_wen[d] === 1'b1) begin
            check(d, K_WR, wrv(pre_idx[d], pre_wdata[d]));
        end
        if (prev_en[d] === 1'b0 && cpu_en[d] === 1'b1) begin
            check(d, K_EN, 80'(since[d] - 1));
        end
        if (prev_bz[d] === 1'b1 && busy[d] === 1'b0) begin
            check(d, K_STOP, stopv(halted[d], timed_out[d], cpu_en[d],
                                   cpu_restart[d], run_cycles[d]));
        end
        if (tok[d] != last_tok[d]) begin
            last_tok[d] = tok[d];
            check(d, K_SNAP, snapv(cpu_restart[d], cpu_en[d], pre_wen[d],
                                   pre_idx[d], pre_wdata[d], busy[d],
                                   halted[d], timed_out[d], run_cycles[d]));
        end
        prev_rs[d] = cpu_restart[d];
        prev_en[d] = cpu_en[d];
        prev_bz[d] = busy[d];
    endtask

    // Edge tracker: cycles since the sequence began and rst history.
    initial forever begin
        @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            if (rst[d] === 1'b1) since[d] = 0;
            else if (start[d] === 1'b1 && busy[d] === 1'b0) since[d] = 1;
            else since[d] = since[d] + 1;
            rst_q[d] = rst[d];
        end
    end

    // Monitor: turns DUT activity into events checked against the queue.
    initial forever begin
        @(negedge clk);
        for (int d = 0; d < 3; d++) observe(d);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic snap(input int d, input logic [79:0] v, input string n);
        push(d, K_SNAP, v, n);
        tok[d]++;
    endtask

    task automatic push_seq(input int d, input int en_cyc);
        push(d, K_RLEN, 80'(5), "restart_len");
        if (d != 2) begin
            push(d, K_WR, wrv(4'd1, 32'h200), "preload0");
            push(d, K_WR, wrv(4'd3, 32'h100), "preload1");
            push(d, K_WR, wrv(4'd4, 32'hff00), "preload2");
        end
        push(d, K_EN, 80'(en_cyc), "en_latency");
    endtask

    task automatic wait_en(input int d);
        int n = 0;
        while (cpu_en[d] !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        total++;
        if (cpu_en[d] !== 1'b1) begin
            bad++;
            $display("FAIL dut%0d wait_en: cpu_en=%b required 1 within 60 cycles",
                     d, cpu_en[d]);
        end
    endtask

    task automatic wait_idle(input int d);
        int n = 0;
        while (busy[d] !== 1'b0 && n < 80) begin
            step();
            n++;
        end
        total++;
        if (busy[d] !== 1'b0) begin
            bad++;
            $display("FAIL dut%0d wait_idle: busy=%b required 0 within 80 cycles",
                     d, busy[d]);
        end
    endtask

    logic [79:0] rstv;

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst[d]   = 1'b1;
            start[d] = 1'b0;
            watch[d] = 32'h0;
        end
        rstv = snapv(1, 0, 0, 4'h0, 32'h0, 1, 0, 0, 32'd0);
        step();
        for (int d = 0; d < 3; d++) snap(d, rstv, "reset_state");
        step();
        step();

        // Defaults: full sequence, then sentinel after 40 RUN cycles.
        push_seq(0, 13);
        rst[0] = 1'b0;
        wait_en(0);
        snap(0, snapv(0, 1, 0, 4'h0, 32'h0, 1, 0, 0, 32'd1), "run_first");
        push(0, K_STOP, stopv(1, 0, 0, 0, 32'd40), "halt_stop");
        repeat (39) step();
        watch[0] = 32'h0000ff00;
        step();
        watch[0] = 32'h0;
        snap(0, snapv(0, 0, 0, 4'h0, 32'h0, 0, 1, 0, 32'd40), "halted_state");
        repeat (3) step();
        snap(0, snapv(0, 0, 0, 4'h0, 32'h0, 0, 1, 0, 32'd40), "halted_hold");
        step();

        // Re-launch from HALTED, then start during RUN is ignored.
        snap(0, snapv(1, 0, 0, 4'h0, 32'h0, 1, 0, 0, 32'd0), "start_clear");
        push_seq(0, 13);
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        wait_en(0);
        start[0] = 1'b1;
        snap(0, snapv(0, 1, 0, 4'h0, 32'h0, 1, 0, 0, 32'd1), "start_in_run");
        step();
        start[0] = 1'b0;
        snap(0, snapv(0, 1, 0, 4'h0, 32'h0, 1, 0, 0, 32'd2), "run_after_start");
        step();

        // Reset from RUN, then reset during the second preload write.
        rst[0] = 1'b1;
        snap(0, rstv, "rst_from_run");
        step();
        step();
        push(0, K_RLEN, 80'(5), "restart_len");
        push(0, K_WR, wrv(4'd1, 32'h200), "preload0");
        push(0, K_WR, wrv(4'd3, 32'h100), "preload1");
        rst[0] = 1'b0;
        repeat (12) step();
        rst[0] = 1'b1;
        snap(0, rstv, "rst_mid_preload");
        step();
        step();
        push_seq(0, 13);
        rst[0] = 1'b0;
        wait_en(0);

        // No preload entries: enable after 10 cycles.
        push_seq(2, 10);
        rst[2] = 1'b0;
        wait_en(2);
        snap(2, snapv(0, 1, 0, 4'h0, 32'h0, 1, 0, 0, 32'd1), "np_run");
        step();

        // Timeout of 20 with watch held at 0.
        push_seq(1, 13);
        push(1, K_STOP, stopv(0, 1, 0, 0, 32'd20), "timeout_stop");
        rst[1] = 1'b0;
        wait_idle(1);
        snap(1, snapv(0, 0, 0, 4'h0, 32'h0, 0, 0, 1, 32'd20), "timeout_state");
        step();

        // Sentinel on the 20th RUN cycle beats the timeout.
        snap(1, snapv(1, 0, 0, 4'h0, 32'h0, 1, 0, 0, 32'd0), "to_start_clear");
        push_seq(1, 13);
        push(1, K_STOP, stopv(1, 0, 0, 0, 32'd20), "match_wins_stop");
        start[1] = 1'b1;
        step();
        start[1] = 1'b0;
        wait_en(1);
        repeat (19) step();
        watch[1] = 32'h0000ff00;
        step();
        watch[1] = 32'h0;
        snap(1, snapv(0, 0, 0, 4'h0, 32'h0, 0, 1, 0, 32'd20), "match_wins_state");
        repeat (5) step();

        foreach (exp_q[i]) begin
            total++;
            bad++;
            $display("FAIL dut%0d %s: got nothing required kind=%0d val=%h",
                     exp_q[i].dut, exp_q[i].name, exp_q[i].kind, exp_q[i].val);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arm_run_ctrl.md
Name: arm_run_ctrl

Overview:
- Synthesizable run controller for the ARM core plus instruction/data memory subsystem; replaces ad-hoc bench sequencing with an on-chip block.
- Sequences core reset, a settle delay, parametrised register preload through the core's debug write port, then enables the core.
- Watches a core register and halts the core on a sentinel value or on a cycle timeout.
- Counts run cycles and can re-launch the sequence on command. Sits between the top level and the arm core's cpu_restart/cpu_en inputs.

Parameters:
- WIDTH, 32: data width of watch and preload values.
- IDX_W, 4: register index width.
- RST_CYCLES, 5: cycles cpu_restart is held after rst releases (≥1).
- SETTLE_CYCLES, 5: cycles between restart release and the first preload (≥0).
- NUM_PRELOAD, 3: number of preload entries (0..15).
- PRELOAD_IDX, {4'd4,4'd3,4'd1}: packed NUM_PRELOAD*IDX_W register indices; entry 0 is in the LSBs.
- PRELOAD_VAL, {32'h0000ff00,32'h00000100,32'h00000200}: packed NUM_PRELOAD*WIDTH values; entry 0 is in the LSBs.
- HALT_VALUE, 32'h0000ff00: sentinel compared against watch_data.
- TIMEOUT_CYCLES, 100000: run-cycle limit; 0 disables the timeout.
- CNT_W, 32: run_cycles width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  single-cycle re-launch request; honoured only in HALTED or TIMEOUT.
- watch_data  in  WIDTH  core register under observation.
- cpu_restart  out  1  core restart.
- cpu_en  out  1  core enable.
- pre_wen  out  1  debug register write strobe.
- pre_idx  out  IDX_W  debug register index.
- pre_wdata  out  WIDTH  debug register data.
- busy  out  1  high in every state except HALTED and TIMEOUT.
- halted  out  1  sticky; sentinel seen.
- timed_out  out  1  sticky; limit reached.
- run_cycles  out  CNT_W  cycles spent in RUN, saturating.

Behaviour:
- All outputs are registered.
- Reset values while rst=1: state HOLD, cpu_restart=1, cpu_en=0, pre_wen=0, pre_idx=0, pre_wdata=0, busy=1, halted=0, timed_out=0, run_cycles=0, internal counter 0.
- States:
  - HOLD → SETTLE: cpu_restart=1 for exactly RST_CYCLES cycles after the first edge with rst=0.
  - SETTLE → PRELOAD: cpu_restart=0, cpu_en=0 for SETTLE_CYCLES cycles. If SETTLE_CYCLES=0, go directly to PRELOAD.
  - PRELOAD → RUN: one write per cycle, entries 0..NUM_PRELOAD-1 in order. pre_wen=1 with the matching pre_idx and pre_wdata. cpu_en stays 0. If NUM_PRELOAD=0, skip directly to RUN.
  - RUN: cpu_en=1 and pre_wen=0. run_cycles increments every RUN cycle and saturates at all-ones.
    - watch_data==HALT_VALUE sampled on an edge → next cycle cpu_en=0, halted=1, go to HALTED.
    - Else, if TIMEOUT_CYCLES≠0 and run_cycles==TIMEOUT_CYCLES-1 → next cycle cpu_en=0, timed_out=1, go to TIMEOUT.
    - Match and timeout on the same edge: the match wins, and timed_out stays 0.
  - HALTED / TIMEOUT: cpu_en=0, cpu_restart=0, busy=0. Flags and run_cycles are held.
    - start=1 → clear the flags and run_cycles, then go to HOLD and replay the full sequence.
- start is ignored in HOLD, SETTLE, PRELOAD and RUN.
- rst in any state, including mid-PRELOAD or RUN, forces reset values on the next edge and aborts any pending preload.
- Latency:
  - First RUN cycle, with cpu_en high, occurs RST_CYCLES+SETTLE_CYCLES+NUM_PRELOAD cycles after the first edge with rst low.
  - Halt response: one edge from the matching sample to cpu_en=0.

Test Plan:
1. Defaults, rst high for 3 cycles then low. Required:
   - cpu_restart high for 5 cycles, then 5 idle cycles.
   - pre_wen writes (1,0x200), (3,0x100), (4,0xff00) on consecutive cycles.
   - cpu_en rises on cycle 13.
2. Defaults, watch_data driven to 0x0000ff00 after 40 RUN cycles. Required: cpu_en=0 and halted=1 on the next edge; run_cycles=40 and then holds; busy=0.
3. TIMEOUT_CYCLES=20, watch_data held at 0. Required: timed_out=1, cpu_en=0, run_cycles=20, halted=0.
4. TIMEOUT_CYCLES=20, watch_data=0xff00 exactly on the 20th RUN cycle. Required: halted=1, timed_out=0.
5. From HALTED, pulse start for 1 cycle. Required: flags and run_cycles clear, cpu_restart reasserts for 5 cycles, full sequence replays. A start pulse during RUN has no effect.
6. Assert rst during the second preload write. Required: pre_wen=0 and cpu_restart=1 on the next edge; after release, the sequence restarts at entry 0. Repeat with NUM_PRELOAD=0: cpu_en rises on cycle 10.
